// File: rtl/bintree_expand.sv
// Weight-to-pattern generator: builds an NDATA-bit word with exactly k ones,
// LANES bits per clock, in thermometer or evenly-spread (Bresenham) placement.
//
//   state | meaning
//   IDLE  | ready for a request; out_data holds the previous word
//   BUILD | writing one LANES-bit chunk per cycle, LSB chunk first
//   HOLD  | word complete, out_valid high until the consumer takes it
module bintree_expand #(
  parameter int NDATA = 128,
  parameter int LANES = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [$clog2(NDATA):0]   in_weight,
  input  logic                     in_mode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NDATA-1:0]         out_data
);

  localparam int NDATA_LOG = $clog2(NDATA);
  localparam logic [NDATA_LOG:0]   NDATA_V  = (NDATA_LOG+1)'(NDATA);
  localparam logic [NDATA_LOG-1:0] LANES_V  = NDATA_LOG'(LANES);
  localparam logic [NDATA_LOG-1:0] LAST_IDX = NDATA_LOG'(NDATA - LANES);

  typedef enum logic [1:0] {IDLE, BUILD, HOLD} state_t;

  state_t                 state_q, state_d;
  logic [NDATA_LOG:0]     k_q;
  logic                   mode_q;
  logic [NDATA_LOG-1:0]   idx_q;
  logic [NDATA_LOG:0]     acc_q, acc_d;
  logic [NDATA_LOG:0]     sum, pos;
  logic [NDATA_LOG:0]     k_sat;
  logic [LANES-1:0]       chunk;
  logic [NDATA-1:0]       out_data_q;
  logic                   accept;

  assign k_sat    = (in_weight > NDATA_V) ? NDATA_V : in_weight;
  assign accept   = in_valid && in_ready;
  assign out_data = out_data_q;

  // acc < NDATA and k <= NDATA, so acc + k always fits in NDATA_LOG+1 bits
  always_comb begin
    acc_d = acc_q;
    chunk = '0;
    sum   = '0;
    pos   = '0;
    for (int j = 0; j < LANES; j++) begin
      pos = {1'b0, idx_q} + (NDATA_LOG+1)'(j);
      if (mode_q) begin
        sum = acc_d + k_q;
        if (sum >= NDATA_V) begin
          chunk[j] = 1'b1;
          acc_d    = sum - NDATA_V;
        end else begin
          acc_d = sum;
        end
      end else begin
        chunk[j] = (pos < k_q);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = !rst;
        if (in_valid && !rst) state_d = BUILD;
      end
      BUILD: begin
        if (idx_q == LAST_IDX) state_d = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      out_data_q <= '0;
      idx_q      <= '0;
      acc_q      <= '0;
      k_q        <= '0;
      mode_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (accept) begin
            k_q        <= k_sat;
            mode_q     <= in_mode;
            out_data_q <= '0;
            idx_q      <= '0;
            acc_q      <= '0;
          end
        end
        BUILD: begin
          out_data_q[idx_q +: LANES] <= chunk;
          idx_q                      <= idx_q + LANES_V;
          acc_q                      <= acc_d;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bintree_expand.sv
// Bench for bintree_expand: directed literal cases plus a k/mode sweep, all
// checked every cycle against a cycle-count/arithmetic model of the block.
module tb_bintree_expand;

  localparam int NDATA  = 128;
  localparam int LANES  = 8;
  localparam int CHUNKS = NDATA / LANES;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [7:0]   in_weight = '0;
  logic         in_mode = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_data;

  int checks   = 0;
  int failures = 0;
  int dut_done = 0;

  bit           m_started = 0;
  bit           m_busy = 0;
  bit           m_valid = 0;
  int           m_cnt = 0;
  int           m_k = 0;
  logic [127:0] m_word = '0;
  logic [127:0] m_pend = '0;

  localparam logic [127:0] ONES = {128{1'b1}};

  bintree_expand #(.NDATA(NDATA), .LANES(LANES)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_weight(in_weight), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Bit i of the spread word is set where floor(i*k/N) steps up.
  function automatic logic [127:0] exp_word(input int k, input bit mode);
    logic [127:0] w;
    w = '0;
    for (int i = 0; i < NDATA; i++) begin
      if (mode) w[i] = (((i + 1) * k) / NDATA) > ((i * k) / NDATA);
      else      w[i] = (i < k);
    end
    return w;
  endfunction

  always @(posedge clk) begin
    m_started = 1;
    if (rst) begin
      m_busy  = 0;
      m_valid = 0;
      m_word  = '0;
    end else if (m_busy) begin
      m_cnt++;
      if (m_cnt == CHUNKS) begin
        m_busy  = 0;
        m_valid = 1;
        m_word  = m_pend;
      end
    end else if (m_valid) begin
      if (out_ready) m_valid = 0;
    end else if (in_valid) begin
      m_k    = (int'(in_weight) > NDATA) ? NDATA : int'(in_weight);
      m_pend = exp_word(m_k, in_mode);
      m_busy = 1;
      m_cnt  = 0;
    end
  end

  always @(negedge clk) begin
    if (m_started) begin
      chk("in_ready", 128'(in_ready), 128'(!m_busy && !m_valid && !rst));
      chk("out_valid", 128'(out_valid), 128'(m_valid));
      if (!m_busy) chk("out_data", out_data, m_word);
      if (out_valid && out_ready) begin
        chk("popcount", 128'($countones(out_data)), 128'(m_k));
        dut_done++;
      end
    end
  end

  task automatic run_dir(input int k, input bit mode, input logic [127:0] lit, input string name);
    int n;
    n = 0;
    @(posedge clk); #1;
    in_valid = 1'b1; in_weight = 8'(k); in_mode = mode;
    @(posedge clk); #1;
    in_valid = 1'b0; in_weight = 8'($urandom_range(0, 255)); in_mode = 1'($urandom_range(0, 1));
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, " latency"}, 128'(n), 128'(CHUNKS));
    chk({name, " data"}, out_data, lit);
    chk({name, " ones"}, 128'($countones(out_data)), 128'((k > NDATA) ? NDATA : k));
    if (out_ready) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_req(input int k, input bit mode, input bit inject);
    int n;
    int start;
    bit seen;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      out_ready = 1'($urandom_range(0, 1));
      n++;
    end
    if (n >= 200) chk("sweep in_ready timeout", 128'(in_ready), 128'(1));
    start = dut_done;
    in_valid = 1'b1; in_weight = 8'(k); in_mode = mode;
    @(posedge clk); #1;
    in_valid = 1'b0; in_weight = 8'($urandom_range(0, 255)); in_mode = 1'($urandom_range(0, 1));
    if (inject) begin
      repeat (5) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      seen = 0;
      repeat (20) begin
        @(posedge clk); #1;
        if (out_valid) seen = 1;
      end
      chk("reset drops request", 128'(seen), 128'(0));
    end else begin
      n = 0;
      while (dut_done == start && n < 100) begin
        @(posedge clk); #1;
        out_ready = 1'($urandom_range(0, 1));
        n++;
      end
      chk("sweep word delivered", 128'(dut_done - start), 128'(1));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] snap;
    logic [127:0] lit3;

    repeat (3) @(posedge clk);
    #1;
    chk("reset in_ready", 128'(in_ready), 128'(0));
    chk("reset out_valid", 128'(out_valid), 128'(0));
    chk("reset out_data", out_data, '0);
    rst = 1'b0;
    #1;
    chk("post-reset in_ready", 128'(in_ready), 128'(1));

    out_ready = 1'b1;
    run_dir(128, 1'b0, ONES, "k128 thermo");
    run_dir(128, 1'b1, ONES, "k128 spread");
    run_dir(64, 1'b1, {8{16'hAAAA}}, "k64 spread");
    run_dir(64, 1'b0, {64'h0, {64{1'b1}}}, "k64 thermo");
    run_dir(0, 1'b0, '0, "k0 thermo");
    run_dir(0, 1'b1, '0, "k0 spread");
    run_dir(200, 1'b1, ONES, "k200 spread");
    run_dir(200, 1'b0, ONES, "k200 thermo");
    run_dir(1, 1'b1, 128'h8000_0000_0000_0000_0000_0000_0000_0000, "k1 spread");
    run_dir(1, 1'b0, 128'h1, "k1 thermo");
    lit3 = (128'd1 << 42) | (128'd1 << 85) | (128'd1 << 127);
    run_dir(3, 1'b1, lit3, "k3 spread");

    out_ready = 1'b0;
    run_dir(100, 1'b0, {28'h0, {100{1'b1}}}, "k100 backpressure");
    snap = out_data;
    for (int c = 0; c < 10; c++) begin
      in_valid  = (c == 3);
      in_weight = 8'd5;
      in_mode   = 1'b0;
      @(posedge clk); #1;
      chk("hold out_valid", 128'(out_valid), 128'(1));
      chk("hold out_data", out_data, snap);
      chk("hold in_ready", 128'(in_ready), 128'(0));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release out_valid", 128'(out_valid), 128'(0));
    chk("release in_ready", 128'(in_ready), 128'(1));
    repeat (3) begin @(posedge clk); #1; end
    chk("k5 pulse ignored", out_data, {28'h0, {100{1'b1}}});

    for (int m = 0; m < 2; m++) begin
      for (int k = 0; k <= NDATA; k++) begin
        if (m == 1 && k == 77) do_req(k, 1'b1, 1'b1);
        do_req(k, 1'(m), 1'b0);
      end
    end

    out_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
